// File: rtl/audio_level_meter.sv
// Multi-channel audio level meter: windowed peak amplitude, quantised level and peak-hold with decay.
// Optional sticky per-channel clip flags are built when LEVEL_METER_CLIP_EN is defined.
module audio_level_meter #(
  parameter int CHANNELS = 1,
  parameter int SAMPLE_W = 12,
  parameter int WINDOW   = 2000,
  parameter int LEVELS   = 16,
  parameter int HOLD_WIN = 5,
  localparam int LW  = $clog2(LEVELS),
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW  = SAMPLE_W - 1
) (
  input  logic                   basys_clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sample_valid,
  input  logic [CHW-1:0]         sample_ch,
  input  logic [SAMPLE_W-1:0]    sample,
  output logic [CHANNELS*LW-1:0] level_raw,
  output logic [CHANNELS*LW-1:0] level_peak,
  output logic [CHANNELS*AW-1:0] amp_max,
  output logic                   level_valid,
  output logic [CHANNELS-1:0]    clip,
  input  logic                   clr_clip
);
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int HW = (HOLD_WIN > 0) ? $clog2(HOLD_WIN + 1) : 1;
  localparam logic [SAMPLE_W-1:0] MID       = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [CW-1:0]       LAST      = CW'(WINDOW - 1);
  localparam logic [HW-1:0]       HOLD_INIT = HW'(HOLD_WIN);

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_int_n;

  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  logic                accept;
  logic                in_range;
  logic                close;
  logic [SAMPLE_W-1:0] diff;
  logic [AW-1:0]       amp;

  assign accept   = en & sample_valid;
  assign in_range = (int'(sample_ch) < CHANNELS);

  // |sample - MID| only reaches MID for sample == 0, which saturates to all-ones.
  always_comb begin
    diff = (sample >= MID) ? (sample - MID) : (MID - sample);
    amp  = diff[SAMPLE_W-1] ? {AW{1'b1}} : diff[AW-1:0];
  end

  logic [CW-1:0] win_cnt_reg;
  logic [CW-1:0] win_cnt_next;
  logic          level_valid_reg;

  assign close = accept && (win_cnt_reg == LAST);

  always_comb begin
    win_cnt_next = win_cnt_reg;
    if (accept) win_cnt_next = close ? '0 : win_cnt_reg + CW'(1);
  end

  always_ff @(posedge basys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      win_cnt_reg     <= '0;
      level_valid_reg <= 1'b0;
    end else begin
      win_cnt_reg     <= win_cnt_next;
      level_valid_reg <= close;
    end
  end

  logic [LW-1:0] raw_w  [CHANNELS];
  logic [LW-1:0] peak_w [CHANNELS];
  logic [AW-1:0] amp_w  [CHANNELS];
  logic          clip_w [CHANNELS];

`ifdef LEVEL_METER_CLIP_EN
  logic clip_sample;
  assign clip_sample = (sample == '0) || (sample == '1);
`else
  logic unused_clr_clip;
  assign unused_clr_clip = clr_clip;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic          hit;
    logic [AW-1:0] run_max_reg, run_max_next, amp_reg;
    logic [LW-1:0] raw_reg, peak_reg, peak_next, lvl_next;
    logic [HW-1:0] hold_reg, hold_next;

    assign hit          = accept && in_range && (sample_ch == CHW'(gi));
    assign run_max_next = (hit && (amp > run_max_reg)) ? amp : run_max_reg;
    assign lvl_next     = run_max_next[AW-1 -: LW];

    always_comb begin
      peak_next = peak_reg;
      hold_next = hold_reg;
      if (lvl_next >= peak_reg) begin
        peak_next = lvl_next;
        hold_next = HOLD_INIT;
      end else if (hold_reg != '0) begin
        hold_next = hold_reg - HW'(1);
      end else begin
        // peak > raw on this branch, so one step down never undershoots raw
        peak_next = peak_reg - LW'(1);
      end
    end

    always_ff @(posedge basys_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        run_max_reg <= '0;
        amp_reg     <= '0;
        raw_reg     <= '0;
        peak_reg    <= '0;
        hold_reg    <= '0;
      end else if (close) begin
        run_max_reg <= '0;
        amp_reg     <= run_max_next;
        raw_reg     <= lvl_next;
        peak_reg    <= peak_next;
        hold_reg    <= hold_next;
      end else begin
        run_max_reg <= run_max_next;
      end
    end

    assign raw_w[gi]  = raw_reg;
    assign peak_w[gi] = peak_reg;
    assign amp_w[gi]  = amp_reg;

`ifdef LEVEL_METER_CLIP_EN
    logic clip_reg;
    always_ff @(posedge basys_clk or negedge rst_int_n) begin
      if (!rst_int_n)               clip_reg <= 1'b0;
      else if (hit && clip_sample)  clip_reg <= 1'b1;
      else if (clr_clip)            clip_reg <= 1'b0;
    end
    assign clip_w[gi] = clip_reg;
`else
    assign clip_w[gi] = 1'b0;
`endif
  end

  always_comb begin
    level_raw  = '0;
    level_peak = '0;
    amp_max    = '0;
    clip       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      level_raw[i*LW +: LW]  = raw_w[i];
      level_peak[i*LW +: LW] = peak_w[i];
      amp_max[i*AW +: AW]    = amp_w[i];
      clip[i]                = clip_w[i];
    end
  end

  assign level_valid = level_valid_reg;

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter: queue-based window model checked every cycle plus directed literals.
module tb_audio_level_meter;
  localparam int CH   = 3;
  localparam int SW   = 12;
  localparam int WIN  = 4;
  localparam int LEV  = 16;
  localparam int HOLD = 2;
  localparam int LW   = 4;
  localparam int CHW  = 2;
  localparam int AW   = 11;
`ifdef LEVEL_METER_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           sample_valid = 1'b0;
  logic           clr_clip = 1'b0;
  logic [CHW-1:0] sample_ch = '0;
  logic [SW-1:0]  sample = '0;
  logic [CH*LW-1:0] level_raw, level_peak;
  logic [CH*AW-1:0] amp_max;
  logic             level_valid;
  logic [CH-1:0]    clip;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  audio_level_meter #(
    .CHANNELS(CH), .SAMPLE_W(SW), .WINDOW(WIN), .LEVELS(LEV), .HOLD_WIN(HOLD)
  ) dut (
    .basys_clk(clk), .rst_n(rst_n), .en(en), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample(sample), .level_raw(level_raw), .level_peak(level_peak),
    .amp_max(amp_max), .level_valid(level_valid), .clip(clip), .clr_clip(clr_clip)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: keep every accepted sample of the open window, reduce at close.
  typedef struct { int ch; int amp; } smp_t;
  smp_t win_q[$];
  int   m_cnt;
  int   m_raw [CH];
  int   m_peak[CH];
  int   m_amp [CH];
  int   m_hold[CH];
  bit   m_clip[CH];
  bit   m_valid;
  int   n_close;

  function automatic int amp_of(input int s);
    int a;
    a = s - 2048;
    if (a < 0) a = -a;
    if (a > 2047) a = 2047;
    return a;
  endfunction

  task automatic model_reset();
    win_q.delete();
    m_cnt = 0;
    m_valid = 0;
    for (int c = 0; c < CH; c++) begin
      m_raw[c] = 0; m_peak[c] = 0; m_amp[c] = 0; m_hold[c] = 0; m_clip[c] = 0;
    end
  endtask

  task automatic close_window();
    int mx, r;
    for (int c = 0; c < CH; c++) begin
      mx = 0;
      foreach (win_q[k]) if (win_q[k].ch == c && win_q[k].amp > mx) mx = win_q[k].amp;
      r = mx / 128;
      m_amp[c] = mx;
      m_raw[c] = r;
      if (r >= m_peak[c]) begin
        m_peak[c] = r;
        m_hold[c] = HOLD;
      end else if (m_hold[c] > 0) begin
        m_hold[c]--;
      end else begin
        m_peak[c] = (m_peak[c] - 1 > r) ? m_peak[c] - 1 : r;
      end
    end
    win_q.delete();
    n_close++;
    $display("window %0d closed: raw=%0d/%0d/%0d peak=%0d/%0d/%0d amp=%0d/%0d/%0d", n_close,
             m_raw[0], m_raw[1], m_raw[2], m_peak[0], m_peak[1], m_peak[2],
             m_amp[0], m_amp[1], m_amp[2]);
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_valid = 0;
      if (CLIP_ON) begin
        for (int c = 0; c < CH; c++) begin
          if (en && sample_valid && int'(sample_ch) == c && (sample == 12'd0 || sample == 12'hFFF))
            m_clip[c] = 1;
          else if (clr_clip)
            m_clip[c] = 0;
        end
      end
      if (en && sample_valid) begin
        if (int'(sample_ch) < CH) win_q.push_back('{ch: int'(sample_ch), amp: amp_of(int'(sample))});
        m_cnt++;
        if (m_cnt == WIN) begin
          close_window();
          m_cnt = 0;
          m_valid = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [CH*LW-1:0] er, ep;
    logic [CH*AW-1:0] ea;
    logic [CH-1:0]    ec;
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        er[c*LW +: LW] = LW'(m_raw[c]);
        ep[c*LW +: LW] = LW'(m_peak[c]);
        ea[c*AW +: AW] = AW'(m_amp[c]);
        ec[c]          = m_clip[c];
      end
      chk("model_level_raw", level_raw, er);
      chk("model_level_peak", level_peak, ep);
      chk("model_amp_max", amp_max, ea);
      chk("model_level_valid", level_valid, m_valid);
      chk("model_clip", clip, ec);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic strobe(input int ch, input int s);
    sample_ch = CHW'(ch);
    sample = SW'(s);
    sample_valid = 1'b1;
    cyc(1);
    sample_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1);
  end

  initial begin
    int exp_pk;
    int vcount;
    cyc(3);
    chk("reset_raw", level_raw, 0);
    chk("reset_peak", level_peak, 0);
    chk("reset_amp", amp_max, 0);
    chk("reset_valid", level_valid, 0);
    chk("reset_clip", clip, 0);
    rst_n = 1'b1;
    cyc(3);
    chk_en = 1'b1;
    en = 1'b1;

    // T1: one channel, single window
    strobe(0, 2048); strobe(0, 2304); strobe(0, 1800);
    chk("t1_no_early_valid", level_valid, 0);
    strobe(0, 2100);
    chk("t1_valid", level_valid, 1);
    chk("t1_amp", amp_max, 33'd256);
    chk("t1_raw", level_raw, 12'h002);
    chk("t1_peak", level_peak, 12'h002);
    cyc(1);
    chk("t1_valid_pulse", level_valid, 0);

    // T2: level 12 then quiet windows, hold 2 then decay
    strobe(0, 3584); repeat (3) strobe(0, 2048);
    chk("t2_raw12", level_raw, 12'h00C);
    chk("t2_peak12", level_peak, 12'h00C);
    for (int k = 1; k <= 15; k++) begin
      repeat (4) strobe(0, 2048);
      exp_pk = (k <= HOLD) ? 12 : ((12 - (k - HOLD) > 0) ? 12 - (k - HOLD) : 0);
      chk($sformatf("t2_peak_w%0d", k), level_peak, exp_pk);
    end
    chk("t2_raw0", level_raw, 0);

    // T3: interleaved channels with an out-of-range tag
    strobe(0, 4095); strobe(1, 2448); strobe(3, 4095); strobe(1, 2100);
    chk("t3_valid", level_valid, 1);
    chk("t3_raw", level_raw, 12'h03F);
    chk("t3_peak", level_peak, 12'h03F);
    chk("t3_amp", amp_max, {11'd0, 11'd400, 11'd2047});
    chk("t3_clip", clip, CLIP_ON ? 3'b001 : 3'b000);

    // T4: en low mid-window with strobes still arriving
    strobe(1, 3048); strobe(0, 2048);
    en = 1'b0;
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      sample_ch = 2'd2;
      sample = 12'd0;
      sample_valid = ((i % 2) == 1);
      cyc(1);
      if (level_valid) vcount++;
    end
    sample_valid = 1'b0;
    chk("t4_no_valid", vcount, 0);
    chk("t4_clip_frozen", clip, CLIP_ON ? 3'b001 : 3'b000);
    en = 1'b1;
    strobe(2, 1408); strobe(0, 2148);
    chk("t4_valid", level_valid, 1);
    chk("t4_raw", level_raw, 12'h570);
    chk("t4_peak", level_peak, 12'h57F);

    // T5: reset discards a partial window
    strobe(0, 3000); strobe(1, 3000); strobe(2, 3000);
    rst_n = 1'b0;
    vcount = 0;
    cyc(1); if (level_valid) vcount++;
    cyc(1); if (level_valid) vcount++;
    chk("t5_raw_rst", level_raw, 0);
    chk("t5_peak_rst", level_peak, 0);
    chk("t5_amp_rst", amp_max, 0);
    chk("t5_clip_rst", clip, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (level_valid) vcount++;
    end
    chk("t5_no_valid", vcount, 0);
    strobe(1, 2304); strobe(1, 2100); strobe(0, 2048); strobe(2, 2048);
    chk("t5_valid", level_valid, 1);
    chk("t5_raw", level_raw, 12'h020);
    chk("t5_peak", level_peak, 12'h020);

    // T6: clip set, set-wins over clear, then lone clear
    strobe(1, 0);
    chk("t6_clip_set", clip, CLIP_ON ? 3'b010 : 3'b000);
    clr_clip = 1'b1;
    strobe(1, 4095);
    clr_clip = 1'b0;
    chk("t6_set_wins", clip, CLIP_ON ? 3'b010 : 3'b000);
    clr_clip = 1'b1;
    cyc(1);
    clr_clip = 1'b0;
    chk("t6_cleared", clip, 0);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
